tick_gen_multi: RTL and testbench

Multi-channel, runtime-programmable fractional tick generator, the parametrised successor to the fixed-rate single-channel bit tick. Each channel runs a phase accumulator whose increment is written at run time through a valid/ready configuration port. Each channel produces an oversample tick (`tick_os_out`) and a bit tick (`tick_bit_out`) every `OS_RATIO` oversample ticks. It sits between the I2C/UART bit engines and the system clock, replacing per-engine compile-time baud dividers.

---
 rtl/tick_gen_multi.sv | 126 ++++++++++++
 tb/tb_tick_gen_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel fractional tick generator: per-channel phase accumulators with a
// valid/ready increment-write port. Optional sync restart is enabled by TICK_GEN_SYNC_EN.
module tick_gen_multi #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 16,
    parameter int OS_RATIO    = 16,
    parameter int DEFAULT_INC = 2416,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [CHANNELS-1:0]  en_in,
    input  logic [CHANNELS-1:0]  sync_in,
    input  logic                 cfg_valid_in,
    output logic                 cfg_ready_out,
    input  logic [CW-1:0]        cfg_chan_in,
    input  logic [ACC_WIDTH-1:0] cfg_inc_in,
    output logic [CHANNELS-1:0]  tick_os_out,
    output logic [CHANNELS-1:0]  tick_bit_out
);

    localparam int OSW = $clog2(OS_RATIO);

    // Config handshake: a write is accepted on any edge where cfg_valid_in and
    // cfg_ready_out are both high; ready is high only in IDLE, so the port takes
    // at most one write every two cycles.
    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

    cfg_state_t           state;
    cfg_state_t           state_next;
    logic [CW-1:0]        shadow_chan;
    logic [ACC_WIDTH-1:0] shadow_inc;
    logic                 accept;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cfg_ready_out = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready_out = 1'b1;
                if (cfg_valid_in) begin
                    accept     = 1'b1;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_chan <= '0;
            shadow_inc  <= '0;
        end else if (accept) begin
            shadow_chan <= cfg_chan_in;
            shadow_inc  <= cfg_inc_in;
        end
    end

`ifndef TICK_GEN_SYNC_EN
    logic unused_sync;
    assign unused_sync = ^sync_in;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [ACC_WIDTH:0]   acc;
        logic [ACC_WIDTH-1:0] inc;
        logic [OSW-1:0]       os_cnt;
        logic                 apply_hit;
        logic                 sync_hit;
        logic                 tick;
        logic                 os_last;

        // Out-of-range channel numbers match no channel, so such writes are dropped.
        assign apply_hit = (state == APPLY) && (shadow_chan == CW'(c));
`ifdef TICK_GEN_SYNC_EN
        assign sync_hit  = sync_in[c];
`else
        assign sync_hit  = 1'b0;
`endif
        assign tick    = acc[ACC_WIDTH] & en_in[c];
        assign os_last = (os_cnt == OSW'(OS_RATIO - 1));

        // APPLY outranks sync so a freshly written rate always starts from phase 0.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                acc    <= '0;
                inc    <= ACC_WIDTH'(DEFAULT_INC);
                os_cnt <= '0;
            end else if (apply_hit) begin
                acc    <= '0;
                inc    <= shadow_inc;
                os_cnt <= '0;
            end else if (sync_hit) begin
                acc    <= '0;
                os_cnt <= OSW'(OS_RATIO / 2);
            end else if (en_in[c]) begin
                acc <= {1'b0, acc[ACC_WIDTH-1:0]} + {1'b0, inc};
                if (tick) begin
                    os_cnt <= os_last ? '0 : os_cnt + 1'b1;
                end
            end
        end

        assign tick_os_out[c]  = tick;
        assign tick_bit_out[c] = tick & os_last;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi (CHANNELS=2, ACC_WIDTH=4, OS_RATIO=4, DEFAULT_INC=4),
// plus a 3-channel instance used to reach an out-of-range channel number.
module tb_tick_gen_multi;

    localparam int EW = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] en;
    logic [1:0] sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_chan;
    logic [3:0] cfg_inc;
    logic [1:0] tick_os;
    logic [1:0] tick_bit;

    logic [2:0] en_b;
    logic [2:0] sync_b;
    logic       cfg_valid_b;
    logic       cfg_ready_b;
    logic [1:0] cfg_chan_b;
    logic [3:0] cfg_inc_b;
    logic [2:0] tick_os_b;
    logic [2:0] tick_bit_b;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    typedef struct {
        logic [3:0] inc;
        int first;
        int os1;
        int bit1;
        int os0;
        int bit0;
    } rate_vec_t;

    rate_vec_t rate_tbl[6];

    tick_gen_multi #(
        .CHANNELS(2), .ACC_WIDTH(4), .OS_RATIO(4), .DEFAULT_INC(4)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .sync_in(sync),
        .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready),
        .cfg_chan_in(cfg_chan), .cfg_inc_in(cfg_inc),
        .tick_os_out(tick_os), .tick_bit_out(tick_bit)
    );

    tick_gen_multi #(
        .CHANNELS(3), .ACC_WIDTH(4), .OS_RATIO(4), .DEFAULT_INC(4)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en_b), .sync_in(sync_b),
        .cfg_valid_in(cfg_valid_b), .cfg_ready_out(cfg_ready_b),
        .cfg_chan_in(cfg_chan_b), .cfg_inc_in(cfg_inc_b),
        .tick_os_out(tick_os_b), .tick_bit_out(tick_bit_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [EW-1:0] act,
                         input logic [EW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, expv);
        end
    endtask

    task automatic reset_dut();
        rst_n       = 1'b0;
        en          = 2'b11;
        sync        = 2'b00;
        cfg_valid   = 1'b0;
        cfg_chan    = 1'b0;
        cfg_inc     = 4'd0;
        en_b        = 3'b111;
        sync_b      = 3'b000;
        cfg_valid_b = 1'b0;
        cfg_chan_b  = 2'd0;
        cfg_inc_b   = 4'd0;
        #1;
        check("reset_ready", 0, EW'(cfg_ready), EW'(1'b1));
        check("reset_ticks", 0, EW'({tick_bit, tick_os}), EW'(0));
        check("reset_ready_b", 0, EW'(cfg_ready_b), EW'(1'b1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: apply one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic step(input logic [1:0] e, input logic [1:0] s, input logic v,
                        input logic ch, input logic [3:0] inc, input logic exp_ready,
                        input logic [1:0] exp_os, input logic [1:0] exp_bit,
                        input string name, input int k);
        logic [EW-1:0] expv;
        en        = e;
        sync      = s;
        cfg_valid = v;
        cfg_chan  = ch;
        cfg_inc   = inc;
        exp_q.push_back(EW'({exp_ready, exp_bit, exp_os}));
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        check(name, k, EW'({cfg_ready, tick_bit, tick_os}), expv);
        @(negedge clk);
    endtask

    initial begin
        int  m_first;
        int  c_os1;
        int  c_bit1;
        int  c_os0;
        int  c_bit0;
        logic p;
        logic q;
        checks = 0;
        errors = 0;

        rate_tbl[0] = '{inc: 4'd6,  first: 3,  os1: 12, bit1: 3, os0: 8, bit0: 2};
        rate_tbl[1] = '{inc: 4'd0,  first: 0,  os1: 0,  bit1: 0, os0: 8, bit0: 2};
        rate_tbl[2] = '{inc: 4'd15, first: 2,  os1: 30, bit1: 7, os0: 8, bit0: 2};
        rate_tbl[3] = '{inc: 4'd4,  first: 4,  os1: 8,  bit1: 2, os0: 8, bit0: 2};
        rate_tbl[4] = '{inc: 4'd8,  first: 2,  os1: 16, bit1: 4, os0: 8, bit0: 2};
        rate_tbl[5] = '{inc: 4'd1,  first: 16, os1: 2,  bit1: 0, os0: 8, bit0: 2};

        // Default rate from reset: oversample every 4 cycles, bit every 16.
        reset_dut();
        for (int k = 1; k <= 32; k++) begin
            p = (k % 4 == 0);
            q = (k % 16 == 0);
            step(2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, {p, p}, {q, q}, "default_rate", k);
        end

        // Rate table: write ch1, then count ticks over a 32-cycle window after the apply edge.
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            step(2'b11, 2'b00, 1'b1, 1'b1, rate_tbl[i].inc, 1'b0, 2'b00, 2'b00, "cfg_accept", 1);
            step(2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 2'b00, 2'b00, "cfg_apply", 2);
            exp_q.push_back(EW'(rate_tbl[i].first));
            exp_q.push_back(EW'(rate_tbl[i].os1));
            exp_q.push_back(EW'(rate_tbl[i].bit1));
            exp_q.push_back(EW'(rate_tbl[i].os0));
            exp_q.push_back(EW'(rate_tbl[i].bit0));
            m_first = 0;
            c_os1 = 0;
            c_bit1 = 0;
            c_os0 = 0;
            c_bit0 = 0;
            for (int m = 1; m <= 32; m++) begin
                @(posedge clk);
                #1;
                if (tick_os[1]) begin
                    c_os1++;
                    if (m_first == 0) m_first = m;
                end
                if (tick_bit[1]) c_bit1++;
                if (tick_os[0]) c_os0++;
                if (tick_bit[0]) c_bit0++;
                @(negedge clk);
            end
            check("rate_first_tick", i, EW'(m_first), exp_q.pop_front());
            check("rate_os1_count", i, EW'(c_os1), exp_q.pop_front());
            check("rate_bit1_count", i, EW'(c_bit1), exp_q.pop_front());
            check("rate_os0_count", i, EW'(c_os0), exp_q.pop_front());
            check("rate_bit0_count", i, EW'(c_bit0), exp_q.pop_front());
        end

        // ch0 disabled for cycles 7..11: phase holds, schedule slips by 5 cycles.
        reset_dut();
        for (int k = 1; k <= 30; k++) begin
            logic e0;
            e0 = !(k >= 7 && k <= 11);
            p = e0 && (k == 4 || (k >= 13 && (k - 13) % 4 == 0));
            q = (k % 4 == 0);
            step({1'b1, e0}, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, {q, p},
                 {(k == 16), (k == 21)}, "enable_gap", k);
        end

        // Sync pulse on ch0 at edge 7.
        reset_dut();
        for (int k = 1; k <= 20; k++) begin
            logic b0;
`ifdef TICK_GEN_SYNC_EN
            p  = (k == 4) || (k >= 11 && (k - 11) % 4 == 0);
            b0 = (k == 15);
`else
            p  = (k % 4 == 0);
            b0 = (k == 16);
`endif
            q = (k % 4 == 0);
            step(2'b11, {1'b0, (k == 7)}, 1'b0, 1'b0, 4'd0, 1'b1, {q, p},
                 {(k == 16), b0}, "sync_pulse", k);
        end

        // Sync and APPLY hit ch0 on the same edge (8): the write wins.
        reset_dut();
        for (int k = 1; k <= 20; k++) begin
            p = (k == 4) || (k >= 10 && k % 2 == 0);
            q = (k % 4 == 0);
            step(2'b11, {1'b0, (k == 8)}, (k == 7), 1'b0, 4'd8, (k != 7), {q, p},
                 {(k == 16), (k == 16)}, "sync_apply_collision", k);
        end

        // Out-of-range channel on the 3-channel instance: handshake completes, rates unchanged.
        reset_dut();
        cfg_valid_b = 1'b1;
        cfg_chan_b  = 2'd3;
        cfg_inc_b   = 4'd1;
        @(posedge clk);
        #1;
        check("bad_chan_accept", 1, EW'(cfg_ready_b), EW'(1'b0));
        @(negedge clk);
        cfg_valid_b = 1'b0;
        @(posedge clk);
        #1;
        check("bad_chan_ready", 2, EW'(cfg_ready_b), EW'(1'b1));
        @(negedge clk);
        for (int k = 3; k <= 20; k++) begin
            @(posedge clk);
            #1;
            p = (k % 4 == 0);
            q = (k == 16);
            check("bad_chan_ticks", k, EW'({tick_bit_b, tick_os_b}), EW'({{3{q}}, {3{p}}}));
            @(negedge clk);
        end

        // Reset asserted while a write to ch0 (inc=1) is in APPLY.
        reset_dut();
        for (int k = 1; k <= 3; k++) begin
            step(2'b11, 2'b00, (k == 3), 1'b0, 4'd1, (k != 3), 2'b00, 2'b00, "pre_reset_write", k);
        end
        reset_dut();
        for (int k = 1; k <= 20; k++) begin
            p = (k % 4 == 0);
            q = (k % 16 == 0);
            step(2'b11, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, {p, p}, {q, q}, "reset_mid_apply", k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
